// File: rtl/shift_reg_led_seq.sv
// Serial LED shift-register sequencer: emits a latched pattern MSB-first as a
// prescaled ce_out/d_out strobe pair, in one-shot or looping playback.
module shift_reg_led_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             loop,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    output logic             ce_out,
    output logic             d_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = $clog2(WIDTH) + 1;
    localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);
    localparam logic [BW-1:0] BitLast   = BW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             loop_q, loop_d;
    logic             ce_q, ce_d;
    logic             d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        reload_d = reload_q;
        loop_d   = loop_q;
        ce_d     = 1'b0;
        d_d      = d_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    shreg_d  = pattern;
                    reload_d = pattern;
                    loop_d   = loop;
                    presc_d  = '0;
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                // stop wins over both a pending strobe and a loop reload
                if (stop) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (presc_q != PrescLast) begin
                    presc_d = presc_q + PW'(1);
                end else begin
                    presc_d = '0;
                    ce_d    = 1'b1;
                    d_d     = shreg_q[WIDTH-1];
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (bitcnt_q != BitLast) begin
                        bitcnt_d = bitcnt_q + BW'(1);
                    end else if (loop_q) begin
                        shreg_d  = reload_q;
                        bitcnt_d = '0;
                    end else begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                d_d     = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            reload_q <= '0;
            loop_q   <= 1'b0;
            ce_q     <= 1'b0;
            d_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            reload_q <= reload_d;
            loop_q   <= loop_d;
            ce_q     <= ce_d;
            d_q      <= d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ce_out = ce_q;
    assign d_out  = d_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_led_seq.sv
// Bench for shift_reg_led_seq: a DIV=4 and a DIV=1 instance, checked every cycle
// against an edge-count reference model plus directed aggregate checks.
module tb_shift_reg_led_seq;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_s[2];
    logic       loop_s[2];
    logic       stop_s[2];
    logic [7:0] pat_s[2];
    logic       obs_ce[2];
    logic       obs_d[2];
    logic       obs_busy[2];
    logic       obs_done[2];

    int checks   = 0;
    int failures = 0;

    // reference model state
    int         cyc = 0;
    int         ph[2];
    int         e_cyc[2];
    logic [7:0] m_pat[2];
    logic       m_lp[2];
    logic       exp_ce[2];
    logic       exp_d[2];
    logic       exp_busy[2];
    logic       exp_done[2];

    // monitor accumulators
    int          nstb[2];
    int          ndone[2];
    logic [63:0] seq[2];

    always #5 clk = ~clk;

    shift_reg_led_seq #(.WIDTH(8), .DIV(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .loop(loop_s[0]), .stop(stop_s[0]),
        .pattern(pat_s[0]), .ce_out(obs_ce[0]), .d_out(obs_d[0]), .busy(obs_busy[0]),
        .done(obs_done[0])
    );

    shift_reg_led_seq #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .loop(loop_s[1]), .stop(stop_s[1]),
        .pattern(pat_s[1]), .ce_out(obs_ce[1]), .d_out(obs_d[1]), .busy(obs_busy[1]),
        .done(obs_done[1])
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Strobe k-th edge after start at multiples of DIV; bit index from strobe number.
    task automatic model_step();
        int k;
        int j;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = 0;
                exp_ce[i] = 0; exp_d[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
            end
            return;
        end
        cyc++;
        for (int i = 0; i < 2; i++) begin
            exp_ce[i]   = 0;
            exp_done[i] = 0;
            if (ph[i] == 0) begin
                exp_busy[i] = 0;
                if (start_s[i]) begin
                    ph[i] = 1; e_cyc[i] = cyc; m_pat[i] = pat_s[i]; m_lp[i] = loop_s[i];
                    exp_busy[i] = 1;
                end
            end else if (ph[i] == 1) begin
                k = cyc - e_cyc[i];
                if (stop_s[i]) begin
                    exp_busy[i] = 0; exp_done[i] = 1; ph[i] = 2;
                end else if (k % div_of(i) == 0) begin
                    j = k / div_of(i) - 1;
                    exp_ce[i] = 1;
                    exp_d[i]  = m_pat[i][W-1-(j%W)];
                    if (!m_lp[i] && j == W - 1) begin
                        exp_busy[i] = 0; exp_done[i] = 1; ph[i] = 2;
                    end else begin
                        exp_busy[i] = 1;
                    end
                end else begin
                    exp_busy[i] = 1;
                end
            end else begin
                exp_busy[i] = 0;
                ph[i] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("ce%0d", i), obs_ce[i], exp_ce[i]);
            check_eq($sformatf("busy%0d", i), obs_busy[i], exp_busy[i]);
            check_eq($sformatf("done%0d", i), obs_done[i], exp_done[i]);
            if (exp_ce[i]) check_eq($sformatf("d%0d", i), obs_d[i], exp_d[i]);
            if (!rst) check_eq($sformatf("d_rst%0d", i), obs_d[i], 1'b0);
            if (obs_ce[i]) begin
                nstb[i]++;
                seq[i] = {seq[i][62:0], obs_d[i]};
            end
            if (obs_done[i]) ndone[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon(input int i);
        nstb[i] = 0; ndone[i] = 0; seq[i] = '0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        while (obs_busy[i] && n < budget) begin
            tick();
            n++;
        end
        check_eq($sformatf("wait_idle%0d", i), obs_busy[i], 1'b0);
        tick();
        tick();
    endtask

    initial begin
        int i;
        int r;
        logic [7:0] p;
        int cnt;
        for (int n = 0; n < 2; n++) begin
            start_s[n] = 0; loop_s[n] = 0; stop_s[n] = 0; pat_s[n] = '0;
            clear_mon(n);
        end

        // reset held with start asserted, then one-shot A5 accepted at release
        start_s[0] = 1; pat_s[0] = 8'hA5;
        repeat (3) tick();
        rst = 1;
        clear_mon(0);
        tick();
        start_s[0] = 0;
        repeat (10) tick();
        start_s[0] = 1; pat_s[0] = 8'hFF;
        repeat (2) tick();
        start_s[0] = 0;
        wait_idle(0, 60);
        check_eq("a5_strobes", nstb[0], 8);
        check_eq("a5_seq", seq[0][7:0], 8'hA5);
        check_eq("a5_done", ndone[0], 1);

        // one-shot of all ones after the ignored mid-pass start
        clear_mon(0);
        start_s[0] = 1; pat_s[0] = 8'hFF;
        tick();
        start_s[0] = 0;
        wait_idle(0, 60);
        check_eq("ff_strobes", nstb[0], 8);
        check_eq("ff_seq", seq[0][7:0], 8'hFF);

        // continuous playback at DIV=1
        start_s[1] = 1; loop_s[1] = 1; pat_s[1] = 8'h81;
        tick();
        start_s[1] = 0; loop_s[1] = 0;
        clear_mon(1);
        repeat (24) tick();
        @(negedge clk);
        #1;
        check_eq("loop_strobes", nstb[1], 24);
        check_eq("loop_seq", seq[1][23:0], 24'h818181);
        check_eq("loop_no_done", ndone[1], 0);
        check_eq("loop_busy", obs_busy[1], 1'b1);
        tick();
        stop_s[1] = 1;
        tick();
        stop_s[1] = 0;
        wait_idle(1, 20);

        // abort a loop run on the edge that would carry the 5th strobe
        start_s[0] = 1; loop_s[0] = 1; pat_s[0] = 8'h5A;
        tick();
        start_s[0] = 0; loop_s[0] = 0;
        clear_mon(0);
        repeat (19) tick();
        stop_s[0] = 1;
        tick();
        stop_s[0] = 0;
        repeat (12) tick();
        check_eq("abort_strobes", nstb[0], 4);
        check_eq("abort_done", ndone[0], 1);

        // asynchronous reset between edges at the 3rd strobe
        p = 8'($urandom);
        start_s[0] = 1; pat_s[0] = p;
        tick();
        start_s[0] = 0;
        clear_mon(0);
        cnt = 0;
        r = 0;
        while (cnt < 3 && r < 40) begin
            tick();
            r++;
            if (obs_ce[0]) cnt++;
        end
        check_eq("arst_reached", cnt, 3);
        #2;
        rst = 0;
        #1;
        check_eq("arst_ce", obs_ce[0], 1'b0);
        check_eq("arst_busy", obs_busy[0], 1'b0);
        tick();
        rst = 1;
        repeat (3) tick();
        check_eq("arst_no_done", ndone[0], 0);
        p = 8'($urandom);
        clear_mon(0);
        start_s[0] = 1; pat_s[0] = p;
        tick();
        start_s[0] = 0;
        wait_idle(0, 60);
        check_eq("arst_strobes", nstb[0], 8);
        check_eq("arst_seq", seq[0][7:0], p);
        check_eq("arst_done", ndone[0], 1);

        // randomized runs; the per-cycle model does the checking
        for (int it = 0; it < 30; it++) begin
            i = int'($urandom % 2);
            pat_s[i] = 8'($urandom);
            loop_s[i] = ($urandom % 3 == 0);
            start_s[i] = 1;
            tick();
            start_s[i] = 0;
            if ($urandom % 2 == 0) begin
                pat_s[i] = 8'($urandom); start_s[i] = 1; loop_s[i] = $urandom;
                tick();
                start_s[i] = 0;
            end
            if (loop_s[i] || ($urandom % 3 == 0)) begin
                r = int'($urandom_range(1, 40));
                repeat (r - 1) tick();
                stop_s[i] = 1;
                tick();
                stop_s[i] = 0;
            end
            loop_s[i] = 0;
            if (obs_busy[i] && ph[i] == 1 && m_lp[i]) begin
                stop_s[i] = 1;
                tick();
                stop_s[i] = 0;
            end
            wait_idle(i, 200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_reg_led_seq.md
Name: shift_reg_led_seq

Overview:
- Sequencer that drives the serial LED shift register: generates its clock-enable strobe and serial data bit.
- Latches a WIDTH-bit pattern on start and emits it MSB-first, one bit per prescaled step, as a ce_out/d_out pair.
- Supports one-shot and continuous (loop) playback, with a synchronous abort.
- Sits between user control logic (buttons/registers) and the shift register's ce_in/d_in inputs.

Parameters:
- WIDTH, 8, pattern length in bits; number of ce_out strobes per pass; WIDTH >= 2.
- DIV, 4, clk cycles per shift step; DIV >= 1 (DIV=1 gives a strobe every cycle).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin playback; sampled only in IDLE.
- loop  input  1  sampled with start; 1 = repeat pattern indefinitely.
- stop  input  1  synchronous abort; honoured in SHIFT state.
- pattern  input  WIDTH  pattern to emit; sampled on the accepted start.
- ce_out  output  1  one-cycle shift strobe to shift register ce_in.
- d_out  output  1  serial data to shift register d_in; valid while ce_out=1.
- busy  output  1  high while a pass is in progress.
- done  output  1  one-cycle pulse after a one-shot pass or an abort completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ce_out=0, d_out=0, busy=0, done=0; prescaler, bit counter, shift register and loop flag all 0. Release is synchronous to the next clk edge.
- All outputs are registered.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E: latch pattern into shreg and into a reload copy; latch loop; clear prescaler and bitcnt; go to SHIFT; busy=1 from E.
  - start=0: remain in IDLE, all outputs 0.
- SHIFT, every edge:
  - If prescaler != DIV-1: prescaler+1, ce_out=0.
  - If prescaler == DIV-1: prescaler=0, ce_out=1, d_out=shreg[WIDTH-1], shreg shifts left (LSB filled with 0), bitcnt+1.
- SHIFT timing:
  - First strobe is visible DIV edges after E.
  - Strobes are exactly DIV cycles apart.
  - WIDTH strobes per pass.
- End of pass (strobe edge with bitcnt==WIDTH-1):
  - loop flag=1: reload shreg from the copy, bitcnt=0, stay in SHIFT. The next strobe follows DIV cycles later with no gap.
  - loop flag=0: go to DONE.
- DONE (one cycle): ce_out=0, busy=0, done=1. The next edge returns to IDLE with done=0.
- d_out holds its last value between strobes; the shift register ignores it while ce_out=0.
- start while busy is ignored; pattern and loop changes mid-pass have no effect.
- stop=1 in SHIFT (any prescaler phase):
  - Next edge goes to DONE; no further strobe, even if that edge would have been a strobe edge.
  - stop takes priority over a strobe and over a loop reload.
- stop in IDLE or DONE: ignored.
- start asserted in DONE: ignored. start must be held or re-asserted once the block is back in IDLE.
- rst=0 mid-pass: immediate return to IDLE, ce_out/busy drop asynchronously, no done pulse.
- Counter widths: prescaler = clog2(DIV) bits (minimum 1); bitcnt = clog2(WIDTH)+1 bits; no wrap-around is possible within range.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> ce_out=busy=done=d_out=0 throughout; no state change until rst=1.
- One-shot, WIDTH=8, DIV=4, pattern=8'hA5, start at edge E:
  - 8 strobes at edges E+4, E+8 … E+32.
  - d_out sequence 1,0,1,0,0,1,0,1.
  - done=1 for exactly one cycle after E+32; busy falls at the same edge.
- Loop, DIV=1, pattern=8'h81, loop=1:
  - ce_out high every cycle.
  - d_out repeats 1,0,0,0,0,0,0,1 for 3 passes with no gap.
  - busy stays 1; done never asserts.
- Abort: during a loop run with DIV=4, assert stop=1 on the edge where prescaler=3:
  - No strobe on that edge.
  - done pulses once, then IDLE.
  - No further ce_out.
- Ignore start: re-assert start with a new pattern=8'hFF mid-pass -> d_out sequence unaffected (original pattern); after done, a new start with 8'hFF -> 8 ones.
- Async reset mid-pass: drop rst between clock edges at the 3rd strobe -> ce_out/busy go 0 immediately; no done pulse; a new start after release plays a full 8-bit pass.
